hold_generator: RTL and testbench
=================================

// Module: hold_generator
// PURPOSE
//  Timed level driver; the transmit-side counterpart of the hold-time counter.
//  Given a duration in ticks and a start strobe, drives lv_out high for exactly that many ticks.
//  A tick is TICK_DIV cycles of CLK100MHZ, so the default 50_000_000 gives 2 Hz ticks (0.5 s).
//  Sits between control logic (FSM/buttons) and a downstream level consumer (LED, actuator, counter).
// PARAMETERS
//  COUNT_BITS  8           width of duration input and internal down-counter
//  TICK_DIV    50_000_000  CLK100MHZ cycles per tick (>=2); 50_000_000 -> 2 Hz tick
// PORTS
//  CLK100MHZ   in   1           system clock, single clock domain, all logic on posedge
//  reset       in   1           asynchronous, active-high; clears all state immediately
//  start       in   1           1-cycle request strobe, sampled only in IDLE
//  hold_count  in   COUNT_BITS  requested duration in ticks, sampled with start
//  abort       in   1           terminate an active hold early
//  lv_out      out  1           generated level, registered
//  busy        out  1           high while in HOLD
//  done        out  1           1-cycle pulse on normal completion
//  remaining   out  COUNT_BITS  ticks left; present only with HOLD_GEN_REMAIN_EN
// BEHAVIOUR
//  - Reset values (async): state=IDLE, lv_out=0, busy=0, done=0, counter=0, prescaler=0.
//  - Single clock only: the tick is a 1-cycle enable (tick_en), never a derived clock.
//  - FSM states: IDLE, HOLD.
//  - IDLE -> HOLD: start=1, abort=0, hold_count!=0. Latch hold_count, clear prescaler.
//    lv_out=1 and busy=1 from the next cycle.
//  - IDLE with start=1 and hold_count==0: stay IDLE, lv_out stays 0, done pulses next cycle.
//  - HOLD: prescaler counts 0..TICK_DIV-1 and raises tick_en on TICK_DIV-1.
//    Each tick_en decrements the counter.
//  - Completion: on tick_en with counter==1, go to IDLE.
//    lv_out=0, busy=0, done=1 for one cycle, all from the next cycle.
//  - lv_out high time is exactly hold_count*TICK_DIV cycles; start-to-rise latency is 1 cycle.
//  - start while in HOLD: ignored; no queuing, no retrigger.
//  - abort in HOLD: IDLE next cycle, lv_out=0, busy=0, NO done pulse; counter cleared.
//  - abort in the same cycle as a completing tick: abort wins, no done.
//  - abort with start in IDLE: abort wins, stays IDLE, no done.
//  - Counter is unsigned and only decrements from a nonzero value, so it never wraps.
//    Maximum duration is 2^COUNT_BITS-1 ticks.
//  - reset asserted mid-HOLD: lv_out drops asynchronously, no done.
// CONFIGURATION
//  - Macro: HOLD_GEN_REMAIN_EN.
//  - Defined: port remaining = live down-counter value. Reset 0, loaded value on the first
//    HOLD cycle, decrements on each tick_en, 0 in IDLE.
//  - Undefined: remaining port absent; behaviour otherwise identical.
// STRUCTURE
//  - Package hold_gen_pkg:
//    - typedef enum logic {IDLE, HOLD} hold_state_t
//    - localparam CLK_FREQ_HZ = 100_000_000
//    - localparam TICK_DIV_2HZ = 50_000_000
//  - Sub-module tick_prescaler #(TICK_DIV):
//    - in: CLK100MHZ, reset, clr, en; out: tick_en
//    - clr is synchronous and has priority over en
//    - counter width $clog2(TICK_DIV)
//  - Top: FSM, down-counter and output registers.
// TESTING  (bench uses TICK_DIV=4, COUNT_BITS=8)
//  - reset held, then released; no start -> lv_out=0, busy=0, done=0 for 50 cycles.
//  - start, hold_count=3 -> lv_out high exactly 12 cycles, rising 1 cycle after start;
//    done=1 the cycle lv_out falls; busy mirrors lv_out.
//  - start, hold_count=0 -> lv_out never rises; done pulses once, 1 cycle after start.
//  - hold_count=5, start again at cycle 6 with hold_count=9 -> ignored; high time 20 cycles.
//  - hold_count=5, abort at cycle 7 -> lv_out=0 next cycle, no done, busy=0;
//    a new start then runs normally.
//  - hold_count=255, async reset pulse between clock edges mid-hold -> lv_out=0 immediately;
//    with HOLD_GEN_REMAIN_EN, remaining=0, and it read 255,254,... every 4 cycles before reset.

Source files
------------

// File: rtl/hold_gen_pkg.sv
// Shared types and clock constants for the hold generator.
package hold_gen_pkg;

    typedef enum logic {IDLE, HOLD} hold_state_t;

    localparam int unsigned CLK_FREQ_HZ  = 100_000_000;
    localparam int unsigned TICK_DIV_2HZ = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK100MHZ into a one-cycle tick enable every TICK_DIV cycles.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick_en
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             at_top;

    assign at_top  = (cnt == CNT_W'(TICK_DIV - 1));
    assign tick_en = en && !clr && at_top;

    // clr outranks en so a fresh hold always starts on a full tick period
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_top ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hold_generator.sv
// Timed level driver: holds lv_out high for hold_count ticks after a start strobe.
// Optional HOLD_GEN_REMAIN_EN exposes the live down-counter on the remaining port.
module hold_generator
    import hold_gen_pkg::*;
#(
    parameter int unsigned COUNT_BITS = 8,
    parameter int unsigned TICK_DIV   = TICK_DIV_2HZ
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    input  logic                  start,
    input  logic [COUNT_BITS-1:0] hold_count,
    input  logic                  abort,
    output logic                  lv_out,
    output logic                  busy,
    output logic                  done
`ifdef HOLD_GEN_REMAIN_EN
    ,
    output logic [COUNT_BITS-1:0] remaining
`endif
);

    hold_state_t           state, state_next;
    logic [COUNT_BITS-1:0] counter, counter_next;
    logic                  lv_next, busy_next, done_next;
    logic                  tick_en;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .clr       (state == IDLE),
        .en        (state == HOLD),
        .tick_en   (tick_en)
    );

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            lv_out  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            lv_out  <= lv_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    // Abort is checked first everywhere so it suppresses both entry and done
    always_comb begin
        state_next   = state;
        counter_next = counter;
        lv_next      = lv_out;
        busy_next    = busy;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                counter_next = '0;
                lv_next      = 1'b0;
                busy_next    = 1'b0;
                if (start && !abort) begin
                    if (hold_count != '0) begin
                        state_next   = HOLD;
                        counter_next = hold_count;
                        lv_next      = 1'b1;
                        busy_next    = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_next   = IDLE;
                    counter_next = '0;
                    lv_next      = 1'b0;
                    busy_next    = 1'b0;
                end else if (tick_en) begin
                    if (counter == COUNT_BITS'(1)) begin
                        state_next   = IDLE;
                        counter_next = '0;
                        lv_next      = 1'b0;
                        busy_next    = 1'b0;
                        done_next    = 1'b1;
                    end else begin
                        counter_next = counter - COUNT_BITS'(1);
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                counter_next = '0;
                lv_next      = 1'b0;
                busy_next    = 1'b0;
            end
        endcase
    end

`ifdef HOLD_GEN_REMAIN_EN
    assign remaining = counter;
`endif

endmodule

// File: tb/tb_hold_generator.sv
// Directed, table-driven bench for hold_generator (TICK_DIV=4, COUNT_BITS=8).
module tb_hold_generator;

    localparam int unsigned CB = 8;
    localparam int unsigned TD = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CB-1:0] hold_count;
    logic          abort;
    logic          lv_out;
    logic          busy;
    logic          done;
    logic [CB-1:0] remaining;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          start;
        logic [CB-1:0] hc;
        logic          abort;
        logic          lv;
        logic          busy;
        logic          done;
        logic [CB-1:0] rem;
    } vec_t;

    vec_t vecs[$];

    hold_generator #(
        .COUNT_BITS (CB),
        .TICK_DIV   (TD)
    ) dut (
        .CLK100MHZ  (clk),
        .reset      (rst),
        .start      (start),
        .hold_count (hold_count),
        .abort      (abort),
        .lv_out     (lv_out),
        .busy       (busy),
        .done       (done)
`ifdef HOLD_GEN_REMAIN_EN
        ,
        .remaining  (remaining)
`endif
    );

`ifndef HOLD_GEN_REMAIN_EN
    assign remaining = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic l, input logic b, input logic d,
                              input logic [CB-1:0] r);
        check({tag, " lv_out"}, 32'(lv_out), 32'(l));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " done"}, 32'(done), 32'(d));
`ifdef HOLD_GEN_REMAIN_EN
        check({tag, " remaining"}, 32'(remaining), 32'(r));
`endif
    endtask

    function automatic void push(input logic s, input logic [CB-1:0] h, input logic a,
                                 input logic l, input logic b, input logic d,
                                 input logic [CB-1:0] r);
        vecs.push_back('{s, h, a, l, b, d, r});
    endfunction

    // One hold of n ticks; optional retrigger or abort at cycle k after start (0 = none)
    function automatic void push_run(input int n, input int retrig_at, input int abort_at);
        push(1'b1, CB'(n), 1'b0, 1'b1, 1'b1, 1'b0, CB'(n));
        for (int k = 1; k <= n * int'(TD); k++) begin
            if (k == abort_at) begin
                push(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
                push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
                push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
                return;
            end else if (k == n * int'(TD)) begin
                push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
            end else if (k == retrig_at) begin
                push(1'b1, CB'(9), 1'b0, 1'b1, 1'b1, 1'b0, CB'(n - k / int'(TD)));
            end else begin
                push(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, CB'(n - k / int'(TD)));
            end
        end
        push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endfunction

    initial begin
        // Idle after reset, no start
        for (int i = 0; i < 50; i++) push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        push_run(3, 0, 0);
        // Zero duration: done only, one cycle after start
        push(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        push_run(5, 6, 0);
        push_run(5, 0, 7);
        push_run(2, 0, 0);
        // Abort with start in IDLE
        push(1'b1, CB'(4), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        // Abort on the completing tick of a 1-tick hold
        push_run(1, 0, 4);

        start = 1'b0;
        hold_count = '0;
        abort = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_outs("reset", 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            start      = vecs[i].start;
            hold_count = vecs[i].hc;
            abort      = vecs[i].abort;
            @(posedge clk);
            #1 check_outs($sformatf("vec%0d", i), vecs[i].lv, vecs[i].busy, vecs[i].done,
                          vecs[i].rem);
        end

        // Maximum duration, then async reset between clock edges
        @(negedge clk);
        start = 1'b1;
        hold_count = CB'(255);
        @(posedge clk);
        #1 check_outs("max start", 1'b1, 1'b1, 1'b0, CB'(255));
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            hold_count = '0;
            @(posedge clk);
            #1 check_outs($sformatf("max k%0d", k), 1'b1, 1'b1, 1'b0, CB'(255 - k / int'(TD)));
        end
        #2 rst = 1'b1;
        #1 check_outs("async reset", 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 check_outs($sformatf("post reset %0d", k), 1'b0, 1'b0, 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
